dma_xfer_ctrl: RTL and testbench
================================

# dma_xfer_ctrl

Single-channel DMA transfer sequencer that drives the shared word-wide memory port. It accepts one descriptor (source, destination, length, mode), then issues the memory reads and writes needed to move or fill up to 16 words. It sits between the DMA register file, which supplies descriptors and observes status, and the memory interface, which uses a req/gnt/rvalid handshake.

## Interface
- MEM_ADDR_WIDTH, 16, byte address width of memory port (from dma_pkg)
- MEM_DATA_WIDTH, 32, memory data width (from dma_pkg)
- MEM_STRB_WIDTH, MEM_DATA_WIDTH/8, byte strobes; also the address increment per word
- MODE, 2, width of mode field
- MAX_TRANS_SIZE, 5, width of length field; legal lengths 0..16
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  descriptor valid; sampled only in IDLE
- src_addr_i  in  MEM_ADDR_WIDTH  source byte address
- dst_addr_i  in  MEM_ADDR_WIDTH  destination byte address
- len_i  in  MAX_TRANS_SIZE  word count
- mode_i  in  MODE  0=COPY (both addresses increment), 1=FILL (write fill_data_i), 2=FIXED_SRC (source address held), 3=illegal
- fill_data_i  in  MEM_DATA_WIDTH  fill pattern, captured at start
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse on rejected descriptor
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  MEM_ADDR_WIDTH  request address
- mem_wdata_o  out  MEM_DATA_WIDTH  write data
- mem_strb_o  out  MEM_STRB_WIDTH  byte enables; all ones on writes, all zeros on reads
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  MEM_DATA_WIDTH  read data

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE + start_i:
  - Capture src, dst, len, mode and fill data into internal registers.
  - mode==3 or len>16 → err_o pulse; stay IDLE; no memory access.
  - len==0 → DONE; no memory access.
  - FILL → WR_REQ; otherwise → RD_REQ.
- RD_REQ: mem_req_o=1, we=0, addr=src. On gnt → RD_WAIT.
- RD_WAIT: mem_req_o=0. On rvalid, latch rdata into the data buffer → WR_REQ.
- WR_REQ: mem_req_o=1, we=1, addr=dst, wdata=buffer (FILL: fill pattern). On gnt:
  - dst += MEM_STRB_WIDTH.
  - src += MEM_STRB_WIDTH, COPY mode only.
  - Decrement the remaining count.
  - Remaining count now 0 → DONE; otherwise → RD_REQ (FILL: stay in WR_REQ).
- DONE: done_o=1 for one cycle → IDLE.
- Addresses wrap modulo 2^MEM_ADDR_WIDTH. Low address bits are passed through unchanged; no alignment check.
- start_i outside IDLE is ignored.
- While mem_req_o=1 and gnt is low, addr, we, wdata and strb are held stable.
- rvalid outside RD_WAIT is ignored.
- Reset, including mid-transfer: state=IDLE; all outputs 0; counters and buffer cleared. The in-flight request is abandoned.

## Timing
- busy_o=1 in every state except IDLE. It rises the cycle after start and falls the cycle after the done_o pulse.
- With start at edge T, the first mem_req_o is visible in cycle T+1.
- COPY with gnt tied high and rvalid 1 cycle after gnt: 3 cycles per word. An N-word transfer has done_o at cycle T+3N+1.
- FILL with gnt tied high: 1 cycle per word, back-to-back writes. done_o at cycle T+N+1.
- len==0: done_o at cycle T+1.
- err_o asserts in cycle T+1; busy_o never rises.
- Gnt wait states stretch RD_REQ/WR_REQ one-for-one. rvalid delay stretches RD_WAIT one-for-one.

## Structure
- Add to dma_pkg:
  - typedef enum dma_state_e for the five states.
  - typedef enum dma_mode_e: COPY=0, FILL=1, FIXED_SRC=2.
  - Constant DMA_ADDR_INC = MEM_STRB_WIDTH.
  - Constant DMA_MAX_LEN = 16.
- No sub-module. The FSM, the two address counters, the length counter and the data buffer live in one module.

## Test plan
- COPY src=0x0100, dst=0x0200, len=4, gnt high, rvalid +1 → reads at 0x0100..0x010C, then writes of the same data to 0x0200..0x020C in order; done_o at T+13.
- FILL dst=0xFFF8, len=3, fill=0xDEADBEEF → writes to 0xFFF8, 0xFFFC, 0x0000 (wrap), strb=0xF; done_o at T+4.
- FIXED_SRC src=0x0040, len=3, gnt stalled 2 cycles per request → all reads at 0x0040; addr and wdata stable during stalls.
- Illegal descriptors:
  - len=17 → err_o pulse at T+1; no mem_req_o.
  - mode=3 → err_o pulse at T+1; no mem_req_o.
  - len=0 → done_o at T+1; no mem_req_o.
- Async rst in RD_WAIT of a len=16 copy → all outputs 0 immediately.
  - A late rvalid is ignored.
  - A new start then runs its transfer correctly.
- start_i pulsed while busy → ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA transfer sequencer
//
// Purpose: memory port geometry, descriptor field widths, FSM state and
// transfer mode encodings used by dma_xfer_ctrl.
package dma_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_STRB_WIDTH = MEM_DATA_WIDTH / 8;
  localparam int MODE           = 2;
  localparam int MAX_TRANS_SIZE = 5;

  // One word step on the byte-addressed memory port.
  localparam logic [MEM_ADDR_WIDTH-1:0] DMA_ADDR_INC = MEM_ADDR_WIDTH'(MEM_STRB_WIDTH);
  localparam logic [MAX_TRANS_SIZE-1:0] DMA_MAX_LEN  = MAX_TRANS_SIZE'(16);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } dma_state_e;

  // Encoding 3 is left unnamed: it is the illegal mode and is rejected at start.
  typedef enum logic [MODE-1:0] {
    COPY      = 2'd0,
    FILL      = 2'd1,
    FIXED_SRC = 2'd2
  } dma_mode_e;

endpackage

// File: rtl/dma_xfer_ctrl.sv
// rtl/dma_xfer_ctrl.sv - single-channel DMA copy/fill sequencer on a req/gnt/rvalid memory port
//
// Purpose: accepts one descriptor in IDLE and moves (COPY, FIXED_SRC) or
// writes (FILL) up to DMA_MAX_LEN words, one memory request at a time.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i ..          descriptor: src/dst byte address, word count, mode, fill data
//   busy_o/done_o/err_o status: in progress, completion pulse, rejection pulse
//   mem_*_o             request side of the memory port (req, we, addr, wdata, strb)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory responses
module dma_xfer_ctrl
  import dma_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [MEM_ADDR_WIDTH-1:0] src_addr_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [MAX_TRANS_SIZE-1:0] len_i,
  input  logic [MODE-1:0]           mode_i,
  input  logic [MEM_DATA_WIDTH-1:0] fill_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
  output logic [MEM_STRB_WIDTH-1:0] mem_strb_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i
);

  dma_state_e                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] src_q, src_d;
  logic [MEM_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [MAX_TRANS_SIZE-1:0] cnt_q, cnt_d;
  logic [MODE-1:0]           mode_q, mode_d;
  logic [MEM_DATA_WIDTH-1:0] fill_q, fill_d;
  logic [MEM_DATA_WIDTH-1:0] buf_q, buf_d;
  logic                      err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    fill_d      = fill_q;
    buf_d       = buf_q;
    err_d       = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    done_o      = 1'b0;
    err_o       = err_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d  = src_addr_i;
          dst_d  = dst_addr_i;
          cnt_d  = len_i;
          mode_d = mode_i;
          fill_d = fill_data_i;
          // All-ones mode is the reserved encoding.
          if ((&mode_i) || (len_i > DMA_MAX_LEN)) begin
            err_d = 1'b1;
          end else if (len_i == '0) begin
            state_d = ST_DONE;
          end else if (mode_i == FILL) begin
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end

      ST_RD_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = src_q;
        if (mem_gnt_i) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (mem_rvalid_i) begin
          buf_d   = mem_rdata_i;
          state_d = ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = dst_q;
        mem_strb_o  = '1;
        mem_wdata_o = (mode_q == FILL) ? fill_q : buf_q;
        if (mem_gnt_i) begin
          dst_d = dst_q + DMA_ADDR_INC;
          // FIXED_SRC keeps re-reading the same source word.
          if (mode_q == COPY) begin
            src_d = src_q + DMA_ADDR_INC;
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == MAX_TRANS_SIZE'(1)) begin
            state_d = ST_DONE;
          end else if (mode_q == FILL) begin
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb/tb_dma_xfer_ctrl.sv - self-checking bench for dma_xfer_ctrl with a memory responder and transaction model
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] src_addr_i, dst_addr_i;
  logic [4:0]  len_i;
  logic [1:0]  mode_i;
  logic [31:0] fill_data_i;
  logic        busy_o, done_o, err_o;
  logic        mem_req_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_strb_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  dma_xfer_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .mode_i(mode_i), .fill_data_i(fill_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  txn_t obs_q[$];
  txn_t exp_q[$];
  int   done_q[$];
  int   err_q[$];
  int   busy_cnt = 0;
  int   cyc      = 0;
  int   cfg_stall = 0;
  int   cfg_rvd   = 1;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  // Memory responder and monitor: acts on the falling edge, so DUT outputs
  // are settled and gnt/rvalid are ready before the next rising edge.
  initial begin : responder
    int          rv_cnt;
    logic [31:0] rv_data;
    bit          req_act;
    int          stall_left;
    txn_t        held;
    rv_cnt = 0; rv_data = '0; req_act = 0; stall_left = 0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rv_data;
        end
      end
      if (done_o) done_q.push_back(cyc);
      if (err_o)  err_q.push_back(cyc);
      if (busy_o) busy_cnt++;
      if (mem_req_o) begin
        if (!req_act) begin
          req_act    = 1;
          stall_left = cfg_stall;
          held.we = mem_we_o; held.addr = mem_addr_o;
          held.wdata = mem_wdata_o; held.strb = mem_strb_o;
        end else begin
          check("hold_stable", {mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o},
                {held.we, held.addr, held.wdata, held.strb});
        end
        if (stall_left > 0) begin
          mem_gnt_i = 1'b0;
          stall_left--;
        end else begin
          mem_gnt_i = 1'b1;
          req_act   = 0;
          obs_q.push_back(held);
          if (!held.we) begin
            rv_cnt  = cfg_rvd;
            rv_data = mem_word(held.addr);
          end
        end
      end else begin
        mem_gnt_i = 1'b0;
        req_act   = 0;
      end
    end
  end

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); done_q.delete(); err_q.delete();
    busy_cnt = 0;
  endtask

  task automatic drive_start(input logic [1:0] mode, input logic [4:0] len,
                             input logic [15:0] src, input logic [15:0] dst,
                             input logic [31:0] fill);
    start_i = 1'b1; mode_i = mode; len_i = len;
    src_addr_i = src; dst_addr_i = dst; fill_data_i = fill;
  endtask

  task automatic run_xfer(input string tag, input logic [1:0] mode, input logic [4:0] len,
                          input logic [15:0] src, input logic [15:0] dst,
                          input logic [31:0] fill, input int stall, input int rvd,
                          input bit poke_busy);
    int   t0;
    int   exp_done;
    int   n;
    bit   illegal;
    txn_t t;
    cfg_stall = stall;
    cfg_rvd   = rvd;
    clear_logs();
    illegal = (mode == 2'd3) || (len > 5'd16);
    if (!illegal) begin
      for (int i = 0; i < int'(len); i++) begin
        if (mode != 2'd1) begin
          t.we = 1'b0; t.wdata = '0; t.strb = 4'h0;
          t.addr = (mode == 2'd2) ? src : src + 16'(4 * i);
          exp_q.push_back(t);
        end
        t.we   = 1'b1;
        t.strb = 4'hF;
        t.wdata = (mode == 2'd1) ? fill
                : mem_word((mode == 2'd2) ? src : src + 16'(4 * i));
        t.addr = dst + 16'(4 * i);
        exp_q.push_back(t);
      end
    end

    @(posedge clk); #2;
    drive_start(mode, len, src, dst, fill);
    t0 = cyc + 1;
    @(posedge clk); #2;
    start_i = 1'b0;
    src_addr_i = 16'($urandom); dst_addr_i = 16'($urandom); fill_data_i = $urandom;
    if (poke_busy) begin
      repeat (3) @(posedge clk);
      #2;
      drive_start(2'd1, 5'd2, 16'h7000, 16'h7100, 32'h1234_5678);
      @(posedge clk); #2;
      start_i = 1'b0;
    end
    for (int k = 0; k < 3000 && done_q.size() == 0 && err_q.size() == 0; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;

    if (illegal) begin
      check({tag, "_err_count"}, err_q.size(), 1);
      check({tag, "_done_count"}, done_q.size(), 0);
      if (err_q.size() > 0) check({tag, "_err_cycle"}, err_q[0], t0 + 1);
      check({tag, "_busy"}, busy_cnt, 0);
      check({tag, "_no_mem"}, obs_q.size(), 0);
    end else begin
      if (mode == 2'd1) exp_done = t0 + 1 + int'(len) * (1 + stall);
      else              exp_done = t0 + 1 + int'(len) * (2 * (1 + stall) + rvd);
      check({tag, "_done_count"}, done_q.size(), 1);
      check({tag, "_err_count"}, err_q.size(), 0);
      if (done_q.size() > 0) check({tag, "_done_cycle"}, done_q[0], exp_done);
      check({tag, "_busy_cycles"}, busy_cnt, exp_done - t0);
      check({tag, "_txn_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_txn%0d_we_addr_strb", tag, i),
              {obs_q[i].we, obs_q[i].addr, obs_q[i].strb},
              {exp_q[i].we, exp_q[i].addr, exp_q[i].strb});
        if (exp_q[i].we)
          check($sformatf("%s_txn%0d_wdata", tag, i), obs_q[i].wdata, exp_q[i].wdata);
      end
    end
  endtask

  initial begin : stimulus
    rst = 1'b1; start_i = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; len_i = '0; mode_i = '0; fill_data_i = '0;
    #1;
    check("reset_outputs", {busy_o, done_o, err_o, mem_req_o, mem_we_o,
                            mem_addr_o, mem_wdata_o, mem_strb_o}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    run_xfer("copy4",   2'd0, 5'd4,  16'h0100, 16'h0200, 32'h0,         0, 1, 0);
    run_xfer("fill3",   2'd1, 5'd3,  16'h0000, 16'hFFF8, 32'hDEADBEEF,  0, 1, 0);
    run_xfer("fixed3",  2'd2, 5'd3,  16'h0040, 16'h0300, 32'h0,         2, 1, 0);
    run_xfer("len17",   2'd0, 5'd17, 16'h0100, 16'h0200, 32'h0,         0, 1, 0);
    run_xfer("mode3",   2'd3, 5'd4,  16'h0100, 16'h0200, 32'h0,         0, 1, 0);
    run_xfer("len0",    2'd0, 5'd0,  16'h0100, 16'h0200, 32'h0,         0, 1, 0);

    // Reset while a 16-word copy sits in RD_WAIT with its read data still due.
    cfg_stall = 0; cfg_rvd = 6;
    clear_logs();
    @(posedge clk); #2;
    drive_start(2'd0, 5'd16, 16'h1000, 16'h2000, 32'h0);
    @(posedge clk); #2;
    start_i = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {busy_o, done_o, err_o, mem_req_o, mem_we_o,
                              mem_addr_o, mem_wdata_o, mem_strb_o}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    clear_logs();
    repeat (10) @(posedge clk);
    #2;
    check("late_rvalid_busy", busy_cnt, 0);
    check("late_rvalid_no_mem", obs_q.size(), 0);
    check("late_rvalid_no_done", done_q.size(), 0);
    run_xfer("after_rst", 2'd0, 5'd5, 16'h0A02, 16'h0B00, 32'h0, 1, 2, 0);

    run_xfer("busy_poke", 2'd0, 5'd4, 16'h0500, 16'h0600, 32'h0, 0, 1, 1);

    for (int r = 0; r < 10; r++) begin
      logic [1:0] m;
      logic [4:0] l;
      m = 2'($urandom_range(0, 2));
      l = 5'($urandom_range(1, 16));
      run_xfer($sformatf("rand%0d", r), m, l, 16'($urandom), 16'($urandom),
               $urandom, $urandom_range(0, 2), $urandom_range(1, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
